// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes and the branch-condition helper.
package cpu_pkg;

  localparam int INSTR_W = 20;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_AND  = 4'h2,
    OP_ANDI = 4'h3,
    OP_NAND = 4'h4,
    OP_NOR  = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JUMP = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BLT  = 4'hA,
    OP_BGT  = 4'hB,
    OP_BLE  = 4'hC,
    OP_BGE  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_NAND = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_SUB  = 3'b100
  } alu_op_e;

  // Branch outcome from the flags of the subtract performed in EXECUTE.
  function automatic logic branch_taken(opcode_e op, logic zero, logic neg);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:  t = zero;
      OP_BLT:  t = neg;
      OP_BGT:  t = !zero && !neg;
      OP_BLE:  t = zero || neg;
      OP_BGE:  t = !neg;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational opcode decode: register-file input-stage flags and ALU op.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_arith_o,
  output logic       is_imm_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic [2:0] alu_op_o
);

  opcode_e op;
  assign op = opcode_e'(opcode_i);

  always_comb begin
    is_arith_o  = 1'b0;
    is_imm_o    = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    alu_op_o    = ALU_ADD;
    case (op)
      OP_ADD:  begin is_arith_o = 1'b1;                  alu_op_o = ALU_ADD;  end
      OP_ADDI: begin is_arith_o = 1'b1; is_imm_o = 1'b1; alu_op_o = ALU_ADD;  end
      OP_AND:  begin is_arith_o = 1'b1;                  alu_op_o = ALU_AND;  end
      OP_ANDI: begin is_arith_o = 1'b1; is_imm_o = 1'b1; alu_op_o = ALU_AND;  end
      OP_NAND: begin is_arith_o = 1'b1;                  alu_op_o = ALU_NAND; end
      OP_NOR:  begin is_arith_o = 1'b1;                  alu_op_o = ALU_NOR;  end
      OP_LD:   alu_op_o = ALU_ADD;
      OP_ST:   begin is_store_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_BEQ, OP_BLT, OP_BGT, OP_BLE, OP_BGE: begin
        is_branch_o = 1'b1;
        alu_op_o    = ALU_SUB;
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencer
// owning the program counter and instruction register, with registered strobes.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic [PC_W-1:0]    pc,
  output logic               isArithmetic,
  output logic               isStore,
  output logic               isBrach,
  output logic               isImmediate,
  output logic [3:0]         reg1_in,
  output logic [3:0]         reg2_in,
  output logic [3:0]         reg3,
  output logic [7:0]         imm,
  output logic [2:0]         alu_op,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_read,
  output logic               halted
);

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic                 reg_write_q, mem_write_q, mem_read_q, halted_q;

  opcode_e              op;
  logic [PC_W-1:0]      br_off;
  logic [PC_W-1:0]      br_target;

  assign op        = opcode_e'(ir_q[19:16]);
  // pc has already advanced past the branch, so the offset is relative to pc+1.
  assign br_off    = PC_W'($signed(ir_q[7:0]));
  assign br_target = pc_q + br_off;

  instr_decoder u_dec (
    .opcode_i    (ir_q[19:16]),
    .is_arith_o  (isArithmetic),
    .is_imm_o    (isImmediate),
    .is_store_o  (isStore),
    .is_branch_o (isBrach),
    .alu_op_o    (alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // Strobes are one-cycle pulses: set only on entry to the state that owns them.
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        S_FETCH: begin
          ir_q    <= instr;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= S_DECODE;
        end
        S_DECODE: state_q <= S_EXECUTE;
        S_EXECUTE: begin
          case (op)
            OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_NAND, OP_NOR: begin
              state_q     <= S_WRITEBACK;
              reg_write_q <= 1'b1;
            end
            OP_LD: begin
              state_q    <= S_MEM;
              mem_read_q <= 1'b1;
            end
            OP_ST: begin
              state_q     <= S_MEM;
              mem_write_q <= 1'b1;
            end
            OP_JUMP: begin
              pc_q    <= ir_q[PC_W-1:0];
              state_q <= S_FETCH;
            end
            OP_BEQ, OP_BLT, OP_BGT, OP_BLE, OP_BGE: begin
              if (branch_taken(op, alu_zero, alu_neg)) pc_q <= br_target;
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (op == OP_LD) begin
            state_q     <= S_WRITEBACK;
            reg_write_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_HALT:      state_q <= S_HALT;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  assign pc        = pc_q;
  assign reg1_in   = ir_q[15:12];
  assign reg2_in   = ir_q[11:8];
  assign reg3      = ir_q[7:4];
  assign imm       = ir_q[7:0];
  assign reg_write = reg_write_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus a random program run checked
// against an instruction-level model (latency table, strobe slots, next-pc rule).
module tb_control_unit;
  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [19:0]     instr;
  logic            alu_zero = 1'b0, alu_neg = 1'b0;
  logic [PC_W-1:0] pc;
  logic            isArithmetic, isStore, isBrach, isImmediate;
  logic [3:0]      reg1_in, reg2_in, reg3;
  logic [7:0]      imm;
  logic [2:0]      alu_op;
  logic            reg_write, mem_write, mem_read, halted;

  logic [19:0]     imem [0:1023];
  int              errors = 0;
  int              checks = 0;
  logic [3:0]      strb;

  always #5 clk = ~clk;
  assign instr = imem[pc];
  assign strb  = {reg_write, mem_write, mem_read, halted};

  control_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .pc(pc), .isArithmetic(isArithmetic), .isStore(isStore), .isBrach(isBrach),
    .isImmediate(isImmediate), .reg1_in(reg1_in), .reg2_in(reg2_in), .reg3(reg3),
    .imm(imm), .alu_op(alu_op), .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .halted(halted)
  );

  // ---- instruction-level reference model ----
  function automatic int latency(input logic [3:0] op);
    if (op <= 4'd5) return 4;
    if (op == 4'd6) return 5;
    if (op == 4'd7) return 4;
    return 3;
  endfunction

  // Expected {reg_write, mem_write, mem_read, halted} in cycle c of an instruction (fetch = 0).
  function automatic logic [3:0] strobe_at(input logic [3:0] op, input int c);
    if (op <= 4'd5 && c == 3) return 4'b1000;
    if (op == 4'd6 && c == 3) return 4'b0001 << 1;
    if (op == 4'd6 && c == 4) return 4'b1000;
    if (op == 4'd7 && c == 3) return 4'b0100;
    return 4'b0000;
  endfunction

  function automatic logic taken(input logic [3:0] op, input logic z, input logic n);
    case (op)
      4'h9: return z;
      4'hA: return n;
      4'hB: return !z && !n;
      4'hC: return z || n;
      4'hD: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // {isArithmetic, isImmediate, isStore, isBrach}
  function automatic logic [3:0] flags_of(input logic [3:0] op);
    return {op <= 4'd5, op == 4'd1 || op == 4'd3, op == 4'd7, op >= 4'd9 && op <= 4'hD};
  endfunction

  function automatic int aluop_of(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h6, 4'h7: return 0;
      4'h2, 4'h3: return 1;
      4'h4: return 2;
      4'h5: return 3;
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD: return 4;
      default: return -1;
    endcase
  endfunction

  // ---- stimulus helpers ----
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) imem[i] = 20'hE0000;
  endtask

  // Leaves the bench at mid-cycle of the first FETCH after reset.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    clear_mem();
    do_reset();
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (strb !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", strb); end
    checks++; if ({reg1_in, reg2_in, imm} !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", {reg1_in, reg2_in, imm}); end
  endtask

  task automatic test_add();
    clear_mem();
    imem[0] = 20'h01230;
    do_reset();
    step(1);
    checks++; if (pc !== 10'd1) begin errors++; $display("FAIL add_pc: got %0d want 1", pc); end
    checks++; if ({isArithmetic, isImmediate, isStore, isBrach} !== 4'b1000) begin errors++; $display("FAIL add_flags: got %b want 1000", {isArithmetic, isImmediate, isStore, isBrach}); end
    checks++; if ({reg1_in, reg2_in, reg3, alu_op} !== {4'd1, 4'd2, 4'd3, 3'd0}) begin errors++; $display("FAIL add_fields: got %h want 1230", {reg1_in, reg2_in, reg3, alu_op}); end
    step(1);
    checks++; if (strb !== 4'b0000) begin errors++; $display("FAIL add_exec_strobe: got %b want 0000", strb); end
    step(1);
    checks++; if (strb !== 4'b1000) begin errors++; $display("FAIL add_wb_strobe: got %b want 1000", strb); end
    step(1);
    checks++; if (strb !== 4'b0000 || pc !== 10'd1) begin errors++; $display("FAIL add_next_fetch: got %b/%0d want 0000/1", strb, pc); end
  endtask

  task automatic test_ld();
    clear_mem();
    imem[0] = 20'h61000;
    do_reset();
    step(3);
    checks++; if (strb !== 4'b0010) begin errors++; $display("FAIL ld_mem_read: got %b want 0010", strb); end
    step(1);
    checks++; if (strb !== 4'b1000) begin errors++; $display("FAIL ld_reg_write: got %b want 1000", strb); end
    step(1);
    checks++; if (strb !== 4'b0000 || pc !== 10'd1) begin errors++; $display("FAIL ld_fetch6: got %b/%0d want 0000/1", strb, pc); end
    step(1);
    checks++; if (pc !== 10'd2) begin errors++; $display("FAIL ld_fetch_done: got %0d want 2", pc); end
  endtask

  task automatic test_beq(input logic z, input logic [PC_W-1:0] want);
    clear_mem();
    imem[5] = 20'h912FE;
    alu_zero = z;
    alu_neg  = 1'b0;
    do_reset();
    step(15);
    checks++; if (pc !== 10'd5) begin errors++; $display("FAIL beq_start_pc: got %0d want 5", pc); end
    step(1);
    checks++; if (isBrach !== 1'b1 || alu_op !== 3'b100) begin errors++; $display("FAIL beq_decode: got %b/%b want 1/100", isBrach, alu_op); end
    step(2);
    checks++; if (pc !== want) begin errors++; $display("FAIL beq_target z=%0b: got %0d want %0d", z, pc, want); end
  endtask

  task automatic test_jump_wrap();
    clear_mem();
    imem[0]    = 20'h803FF;
    imem[1023] = 20'h803FF;
    do_reset();
    step(3);
    checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL jump_to_top: got %0d want 1023", pc); end
    step(1);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL fetch_wrap: got %0d want 0", pc); end
    imem[1023] = 20'hE0000;
    step(2);
    checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL jump_self: got %0d want 1023", pc); end
    step(3);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL nop_wrap: got %0d want 0", pc); end
  endtask

  task automatic test_st_abort();
    clear_mem();
    imem[0] = 20'h71200;
    do_reset();
    step(2);
    checks++; if (isStore !== 1'b1) begin errors++; $display("FAIL st_is_store: got %b want 1", isStore); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (strb !== 4'b0000 || pc !== 10'd0) begin errors++; $display("FAIL st_abort: got %b/%0d want 0000/0", strb, pc); end
    step(1);
    checks++; if (strb !== 4'b0000 || pc !== 10'd1) begin errors++; $display("FAIL st_refetch: got %b/%0d want 0000/1", strb, pc); end
  endtask

  task automatic test_halt();
    int bad;
    clear_mem();
    imem[0] = 20'hF0000;
    do_reset();
    step(3);
    checks++; if (strb !== 4'b0001 || pc !== 10'd1) begin errors++; $display("FAIL halt_enter: got %b/%0d want 0001/1", strb, pc); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (strb !== 4'b0001 || pc !== 10'd1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (strb !== 4'b0000 || pc !== 10'd0) begin errors++; $display("FAIL halt_reset: got %b/%0d want 0000/0", strb, pc); end
    step(1);
    checks++; if (pc !== 10'd1 || halted !== 1'b0) begin errors++; $display("FAIL halt_restart: got %0d/%b want 1/0", pc, halted); end
  endtask

  task automatic test_random();
    logic [PC_W-1:0] mpc;
    logic [19:0]     ins;
    logic [3:0]      op;
    logic            z, n;
    int              lat, aop;
    for (int i = 0; i < 1024; i++)
      imem[i] = {4'($urandom_range(0, 14)), 16'($urandom)};
    do_reset();
    mpc = '0;
    for (int k = 0; k < 200; k++) begin
      checks++; if (pc !== mpc || strb !== 4'b0000) begin errors++; $display("FAIL rnd_fetch[%0d]: got pc=%0d strb=%b want pc=%0d strb=0000", k, pc, strb, mpc); end
      ins = imem[mpc];
      op  = ins[19:16];
      z   = 1'($urandom);
      n   = 1'($urandom);
      alu_zero = z;
      alu_neg  = n;
      lat = latency(op);
      for (int c = 1; c < lat; c++) begin
        step(1);
        checks++; if (strb !== strobe_at(op, c)) begin errors++; $display("FAIL rnd_strobe[%0d] op=%h c=%0d: got %b want %b", k, op, c, strb, strobe_at(op, c)); end
        if (c == 1) begin
          checks++; if ({isArithmetic, isImmediate, isStore, isBrach} !== flags_of(op)) begin errors++; $display("FAIL rnd_flags[%0d] op=%h: got %b want %b", k, op, {isArithmetic, isImmediate, isStore, isBrach}, flags_of(op)); end
          checks++; if ({reg1_in, reg2_in, reg3, imm} !== {ins[15:4], ins[7:0]}) begin errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", k, {reg1_in, reg2_in, reg3, imm}, {ins[15:4], ins[7:0]}); end
          aop = aluop_of(op);
          if (aop >= 0) begin
            checks++; if (int'(alu_op) !== aop) begin errors++; $display("FAIL rnd_aluop[%0d] op=%h: got %0d want %0d", k, op, alu_op, aop); end
          end
        end
      end
      mpc = mpc + 10'd1;
      if (op == 4'h8) mpc = ins[PC_W-1:0];
      else if (taken(op, z, n)) mpc = mpc + {{2{ins[7]}}, ins[7:0]};
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_beq(1'b1, 10'd4);
    test_beq(1'b0, 10'd6);
    test_jump_wrap();
    test_st_abort();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
